// File: rtl/ksa_pkg.sv
// ksa_pkg: shared width default and p/g word type for the Kogge-Stone adder datapath
package ksa_pkg;
  localparam int KSA_W = 16;
  typedef struct packed {
    logic [KSA_W-1:0] p;
    logic [KSA_W-1:0] g;
    logic             cin;
  } ksa_pg_word_t;
endpackage

// File: rtl/ksa_pg_cell.sv
// ksa_pg_cell: 1-bit propagate/generate leaf cell
module ksa_pg_cell (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
endmodule

// File: rtl/ksa_preproc_stage.sv
// ksa_preproc_stage: registered p/g pre-processing stage with a two-entry skid buffer
// Define KSA_SUB_EN to add the sub_in port and two's-complement subtract.
module ksa_preproc_stage
  import ksa_pkg::*;
#(
  parameter int W = KSA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
`ifdef KSA_SUB_EN
  input  logic         sub_in,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p_out,
  output logic [W-1:0] g_out,
  output logic         cin_out
);
  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic         cin;
  } word_t;
  logic [W-1:0] b_eff, p_w, g_w;
  logic         cin_eff, accept, load, skid_valid, skid_nxt;
  word_t        in_word, out_word, skid_word;
`ifdef KSA_SUB_EN
  assign b_eff   = b_in ^ {W{sub_in}};
  assign cin_eff = cin_in | sub_in;
`else
  assign b_eff   = b_in;
  assign cin_eff = cin_in;
`endif
  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_cell
      ksa_pg_cell u_cell (.a(a_in[i]), .b(b_eff[i]), .p(p_w[i]), .g(g_w[i]));
    end
  endgenerate
  assign in_word  = '{p: p_w, g: g_w, cin: cin_eff};
  assign accept   = in_valid & in_ready;
  assign load     = ~out_valid | out_ready;
  // skid only ever fills while the output is stalled; it drains whenever the output can load
  assign skid_nxt = ~load & (skid_valid | accept);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_word   <= '0;
      skid_word  <= '0;
    end else begin
      skid_valid <= skid_nxt;
      in_ready   <= ~skid_nxt;
      if (load) begin
        out_valid <= skid_valid | accept;
        if (skid_valid) out_word <= skid_word;
        else if (accept) out_word <= in_word;
      end else if (accept) begin
        skid_word <= in_word;
      end
    end
  end
  assign p_out   = out_word.p;
  assign g_out   = out_word.g;
  assign cin_out = out_word.cin;
endmodule

// File: doc/ksa_preproc_stage.md
# ksa_preproc_stage

Registered pre-processing stage of the Kogge-Stone adder datapath. It sits directly upstream of the prefix tree. It captures operands through a valid/ready handshake and computes per-bit propagate `p = a ^ b` and generate `g = a & b`. It presents them, with the carry-in, to the first rank of prefix cells. A two-entry skid buffer gives full throughput under backpressure with no combinational path from `out_ready` to `in_ready`.

## Interface
- `W`, 16: operand width in bits, at least 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; **synchronous, active-high**; single clock domain.
- `in_valid`  in  1  operand word valid.
- `in_ready`  out  1  stage can accept a word; registered.
- `a_in`  in  W  operand A.
- `b_in`  in  W  operand B.
- `cin_in`  in  1  carry-in.
- `sub_in`  in  1  subtract select; present only with `KSA_SUB_EN`.
- `out_valid`  out  1  p/g word valid.
- `out_ready`  in  1  prefix tree accepts the word.
- `p_out`  out  W  bitwise propagate, `a ^ b_eff`.
- `g_out`  out  W  bitwise generate, `a & b_eff`.
- `cin_out`  out  1  effective carry-in.

## Operation
- Effective operands: `b_eff = b_in`, `cin_eff = cin_in` (see Configuration for subtract).
- Word = {p, g, cin}, computed combinationally from the inputs and stored as one unit.
- Storage:
  - output register: `out_valid`, `p_out`, `g_out`, `cin_out`.
  - skid register: `skid_valid` plus one word.
- `in_ready = ~skid_valid`, registered.
- Accept = `in_valid & in_ready`. Transfer out = `out_valid & out_ready`.
- Update rules, per cycle:
  - Output empty or transferring out, skid full: output loads the skid word, skid clears.
  - Output empty or transferring out, skid empty, accept: output loads the input word.
  - Output empty or transferring out, nothing to load: `out_valid` drops to 0.
  - Output full, not transferring, accept: input word goes to skid, `skid_valid` = 1.
- Ordering is strict FIFO; no word is dropped or duplicated.
- Data outputs are held stable while `out_valid & ~out_ready`.
- Upstream must hold `a_in`/`b_in`/`cin_in` stable while `in_valid & ~in_ready`.

## Timing
- Latency: 1 cycle from accept to `out_valid`. A word taken through the skid adds 1 cycle per stalled cycle.
- Throughput: 1 word per cycle while `out_ready` = 1.
- `in_ready` falls on the cycle after a word lands in the skid. It rises on the cycle after the skid drains.
- Reset values: `out_valid` 0, `skid_valid` 0, `in_ready` 1, `p_out` 0, `g_out` 0, `cin_out` 0.
- Reset mid-operation: both registers are emptied on the next edge and held words are discarded. Inputs are ignored while `rst` = 1.
- `W` = 1 is legal; no wrap-around arithmetic occurs in this stage.

## Configuration
- `KSA_SUB_EN` defined:
  - `sub_in` port exists.
  - `b_eff = b_in ^ {W{sub_in}}`, `cin_eff = cin_in | sub_in` (two's-complement subtract, A - B).
  - `sub_in` is sampled with the operands on accept.
- `KSA_SUB_EN` undefined:
  - `sub_in` port is absent.
  - Add only: `b_eff = b_in`, `cin_eff = cin_in`.

## Structure
- Shared package `ksa_pkg`:
  - default width constant `KSA_W` = 16.
  - packed struct typedef `ksa_pg_word_t` {p[W], g[W], cin}, reused by the prefix tree and post-processing stages.
- Sub-module `ksa_pg_cell`: 1-bit pre-processing cell, `p = a ^ b`, `g = a & b`. Instantiated W times in a generate loop; the companion leaf of the prefix combine cell.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `in_valid` = 1 → `out_valid` = 0, all data outputs 0; `in_ready` = 1 after reset is released.
- Single add: W = 16, `a` = 0x00FF, `b` = 0x0F0F, `cin` = 1, `out_ready` = 1 → one cycle later `out_valid` = 1, `p_out` = 0x0FF0, `g_out` = 0x000F, `cin_out` = 1.
- Backpressure: `out_ready` = 0, push words 1 and 2 → word 2 sits in the skid and `in_ready` = 0 next cycle; word 3 is held. Raise `out_ready` → words 1, 2, 3 emerge in order, no loss or duplicates.
- Streaming: 100 back-to-back random words with `out_ready` = 1 → 100 outputs on consecutive cycles, each matching the reference p/g with latency 1.
- Subtract (`KSA_SUB_EN`): `a` = 0x0005, `b` = 0x0003, `sub` = 1, `cin` = 0 → `p_out` = 0xFFF9, `g_out` = 0x0004, `cin_out` = 1.
- Mid-operation reset: output and skid both full, `out_ready` = 0, assert `rst` for 1 cycle → next cycle `out_valid` = 0, `in_ready` = 1; held words never appear.
